i2c_reg_ctrl: RTL and testbench

- Controller sitting between i2c_slave and an on-chip register bank.
- Sequences slave byte events into register accesses: first written byte sets a register pointer, further written bytes write the bank, reads fetch from the bank.
- Auto-increments the pointer on every data byte.
- Synchronizes the slave's event strobes into the system clock domain and drives the slave's ready/data_in read handshake.

---
 rtl/i2c_reg_pkg.sv | 17 +
 rtl/i2c_sync_edge.sv | 30 +++
 rtl/i2c_reg_ctrl.sv | 134 +++++++++++++
 tb/tb_i2c_reg_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_reg_pkg.sv
// Shared types and constants for the I2C register-bank controller.
// Holds the controller state encoding, byte width and default address width.
package i2c_reg_pkg;

    localparam int BYTE_W = 8;
    localparam int DEF_AW = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PTR      = 3'd1,
        ST_WR_DATA  = 3'd2,
        ST_RD_FETCH = 3'd3,
        ST_RD_LOAD  = 3'd4,
        ST_RD_HOLD  = 3'd5
    } state_t;

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchronizer followed by a rising-edge detector.
// Ports: clk, rst (sync, active-high), sig_in (async level), pulse (1-cycle).
module i2c_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic pulse
);

    // Never fewer than two flops, whatever the caller asks for.
    localparam int N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [N-1:0] sync_q;
    logic         last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[N-2:0], sig_in};
            last_q <= sync_q[N-1];
        end
    end

    assign pulse = sync_q[N-1] & ~last_q;

endmodule

// File: rtl/i2c_reg_ctrl.sv
// Sequences i2c_slave byte events into register-bank reads and writes.
// Ports: clk/rst; slave side i2c_data_out, i2c_r_w, i2c_data_vld, i2c_start,
// i2c_stop in and i2c_ready, i2c_data_in out; bank side reg_addr, reg_wdata,
// reg_we, reg_re out and reg_rdata in; busy out (state is not IDLE).
module i2c_reg_ctrl
    import i2c_reg_pkg::*;
#(
    parameter int AW          = DEF_AW,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] i2c_data_out,
    input  logic              i2c_r_w,
    input  logic              i2c_data_vld,
    input  logic              i2c_start,
    input  logic              i2c_stop,
    output logic              i2c_ready,
    output logic [BYTE_W-1:0] i2c_data_in,
    output logic [AW-1:0]     reg_addr,
    output logic [BYTE_W-1:0] reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [BYTE_W-1:0] reg_rdata,
    output logic              busy
);

    logic ev_data;
    logic ev_start;
    logic ev_stop;

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_data (
        .clk    (clk),
        .rst    (rst),
        .sig_in (i2c_data_vld),
        .pulse  (ev_data)
    );

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_start (
        .clk    (clk),
        .rst    (rst),
        .sig_in (i2c_start),
        .pulse  (ev_start)
    );

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_stop (
        .clk    (clk),
        .rst    (rst),
        .sig_in (i2c_stop),
        .pulse  (ev_stop)
    );

    // Resolve same-cycle events: start beats stop beats data.
    logic do_start;
    logic do_stop;
    logic do_data;

    assign do_start = ev_start;
    assign do_stop  = ev_stop & ~ev_start;
    assign do_data  = ev_data & ~ev_start & ~ev_stop;

    state_t        state;
    state_t        state_n;
    logic [AW-1:0] ptr;

    always_comb begin
        state_n = state;
        if (do_start) begin
            state_n = i2c_r_w ? ST_RD_FETCH : ST_PTR;
        end else if (do_stop) begin
            state_n = ST_IDLE;
        end else begin
            unique case (state)
                ST_PTR:      if (do_data) state_n = ST_WR_DATA;
                ST_RD_FETCH: state_n = ST_RD_LOAD;
                ST_RD_LOAD:  state_n = ST_RD_HOLD;
                ST_RD_HOLD:  if (do_data) state_n = ST_RD_FETCH;
                default:     state_n = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            reg_addr    <= '0;
            reg_wdata   <= '0;
            reg_we      <= 1'b0;
            i2c_ready   <= 1'b0;
            i2c_data_in <= '0;
        end else begin
            state  <= state_n;
            reg_we <= 1'b0;
            if (do_start || do_stop) begin
                i2c_ready <= 1'b0;
            end else begin
                unique case (state)
                    ST_PTR: begin
                        if (do_data) ptr <= i2c_data_out[AW-1:0];
                    end
                    ST_WR_DATA: begin
                        if (do_data) begin
                            reg_we    <= 1'b1;
                            reg_addr  <= ptr;
                            reg_wdata <= i2c_data_out;
                            ptr       <= ptr + AW'(1);
                        end
                    end
                    ST_RD_LOAD: begin
                        // Bank data arrives one cycle after the fetch.
                        i2c_data_in <= reg_rdata;
                        i2c_ready   <= 1'b1;
                        ptr         <= ptr + AW'(1);
                    end
                    ST_RD_HOLD: begin
                        if (do_data) i2c_ready <= 1'b0;
                    end
                    default: ;
                endcase
            end
            // Present the fetch address together with reg_re.
            if (state_n == ST_RD_FETCH) reg_addr <= ptr;
        end
    end

    assign reg_re = (state == ST_RD_FETCH);
    assign busy   = (state != ST_IDLE);

    a_we_re_excl: assert property (
        @(posedge clk) disable iff (rst) !(reg_we && reg_re)
    );

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Randomized scoreboard bench for i2c_reg_ctrl.
// A transaction-level model predicts bank writes, fetch addresses and read bytes.
module tb_i2c_reg_ctrl;

    localparam int AW    = 4;
    localparam int SYNC  = 2;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] i2c_data_out = 8'h00;
    logic       i2c_r_w = 1'b0;
    logic       i2c_data_vld = 1'b0;
    logic       i2c_start = 1'b0;
    logic       i2c_stop = 1'b0;
    logic       i2c_ready;
    logic [7:0] i2c_data_in;
    logic [3:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata = 8'h00;
    logic       busy;

    always #5 clk = ~clk;

    i2c_reg_ctrl #(.AW(AW), .SYNC_STAGES(SYNC)) dut (
        .clk          (clk),
        .rst          (rst),
        .i2c_data_out (i2c_data_out),
        .i2c_r_w      (i2c_r_w),
        .i2c_data_vld (i2c_data_vld),
        .i2c_start    (i2c_start),
        .i2c_stop     (i2c_stop),
        .i2c_ready    (i2c_ready),
        .i2c_data_in  (i2c_data_in),
        .reg_addr     (reg_addr),
        .reg_wdata    (reg_wdata),
        .reg_we       (reg_we),
        .reg_re       (reg_re),
        .reg_rdata    (reg_rdata),
        .busy         (busy)
    );

    typedef struct {
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;

    int         n_checks = 0;
    int         n_fail = 0;
    wr_t        exp_wr[$];
    logic [3:0] exp_ra[$];
    logic [7:0] exp_rd[$];
    logic [7:0] wq[$];
    logic [7:0] mbank[DEPTH];
    logic [7:0] pbank[DEPTH];
    int         mptr = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Register bank peripheral: registered read data.
    always @(posedge clk) begin
        if (reg_we) pbank[reg_addr] <= reg_wdata;
        if (reg_re) reg_rdata <= pbank[reg_addr];
    end

    // Monitor: pops expectations whenever the DUT shows an access or a byte.
    logic ready_q = 1'b0;
    wr_t  e_wr;
    always @(negedge clk) begin
        if (rst) begin
            ready_q = 1'b0;
        end else begin
            if (reg_we && reg_re) check("we_re_exclusive", 1, 0);
            if (reg_we) begin
                if (exp_wr.size() == 0) begin
                    check("unexpected_we", 1, 0);
                end else begin
                    e_wr = exp_wr.pop_front();
                    check("wr_addr", reg_addr, e_wr.a);
                    check("wr_data", reg_wdata, e_wr.d);
                end
            end
            if (reg_re) begin
                if (exp_ra.size() == 0) check("unexpected_re", 1, 0);
                else check("rd_addr", reg_addr, exp_ra.pop_front());
            end
            if (i2c_ready && !ready_q) begin
                if (exp_rd.size() == 0) check("unexpected_ready", 1, 0);
                else check("rd_byte", i2c_data_in, exp_rd.pop_front());
            end
            ready_q = i2c_ready;
        end
    end

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(logic [7:0] d);
        i2c_data_out = d;
        tick(1);
        i2c_data_vld = 1'b1;
        tick(5);
        i2c_data_vld = 1'b0;
        tick(4);
    endtask

    task automatic wait_ready();
        int c;
        c = 0;
        while (!i2c_ready && c < 40) begin
            tick(1);
            c++;
        end
        check("ready_wait", i2c_ready, 1);
    endtask

    task automatic do_start(logic rw, logic with_stop);
        int c;
        i2c_r_w = rw;
        i2c_start = 1'b1;
        if (with_stop) i2c_stop = 1'b1;
        if (rw) begin
            c = 0;
            while (!i2c_ready && c < 40) begin
                @(negedge clk);
                c++;
                if (c == 4) begin
                    i2c_start = 1'b0;
                    i2c_stop = 1'b0;
                end
            end
            check("start_to_ready_in_budget", (c <= SYNC + 4) && i2c_ready, 1);
            i2c_start = 1'b0;
            i2c_stop = 1'b0;
            tick(4);
        end else begin
            tick(4);
            i2c_start = 1'b0;
            i2c_stop = 1'b0;
            tick(4);
        end
    endtask

    task automatic do_stop();
        i2c_stop = 1'b1;
        tick(4);
        i2c_stop = 1'b0;
        tick(3);
        check("busy_after_stop", busy, 0);
    endtask

    task automatic wr_xfer(logic [7:0] p, int n, logic end_stop);
        logic [7:0] d;
        wr_t        e;
        do_start(1'b0, 1'b0);
        send_byte(p);
        mptr = int'(p) % DEPTH;
        for (int i = 0; i < n; i++) begin
            if (wq.size() != 0) d = wq.pop_front();
            else d = 8'($urandom);
            e.a = 4'(mptr);
            e.d = d;
            exp_wr.push_back(e);
            mbank[mptr] = d;
            mptr = (mptr + 1) % DEPTH;
            send_byte(d);
        end
        if (end_stop) do_stop();
    endtask

    // A read of n bytes prefetches n+1 bank locations.
    task automatic rd_xfer(int n, logic with_stop_edge, logic end_stop);
        for (int i = 0; i <= n; i++) begin
            exp_ra.push_back(4'((mptr + i) % DEPTH));
            exp_rd.push_back(mbank[(mptr + i) % DEPTH]);
        end
        mptr = (mptr + n + 1) % DEPTH;
        do_start(1'b1, with_stop_edge);
        for (int i = 0; i < n; i++) begin
            if (i != 0) wait_ready();
            send_byte(8'($urandom));
        end
        if (n != 0) wait_ready();
        if (end_stop) do_stop();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mbank[i] = 8'($urandom);
            pbank[i] = mbank[i];
        end
        tick(3);
        check("rst_ready", i2c_ready, 0);
        check("rst_data_in", i2c_data_in, 0);
        check("rst_we", reg_we, 0);
        check("rst_re", reg_re, 0);
        check("rst_busy", busy, 0);
        check("rst_addr", reg_addr, 0);
        rst = 1'b0;
        tick(3);

        // Write burst: pointer 3, then 0xAA, 0x55.
        wq.push_back(8'hAA);
        wq.push_back(8'h55);
        wr_xfer(8'h03, 2, 1'b1);

        // Read from pointer 5.
        mbank[5] = 8'h11;
        pbank[5] = 8'h11;
        mbank[6] = 8'h22;
        pbank[6] = 8'h22;
        rd_xfer(1, 1'b0, 1'b1);

        // Pointer byte wider than AW wraps to 15, then 0.
        wr_xfer(8'hFF, 2, 1'b1);

        // Repeated start: pointer write then read without stop.
        wr_xfer(8'h02, 0, 1'b0);
        rd_xfer(0, 1'b0, 1'b1);

        // Byte events while idle must be ignored.
        send_byte(8'($urandom));
        tick(5);
        check("idle_byte_busy", busy, 0);

        // Start and stop in the same cycle: start wins.
        rd_xfer(0, 1'b1, 1'b1);

        // Reset while holding a read byte.
        rd_xfer(0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrd_rst_ready", i2c_ready, 0);
        check("midrd_rst_data_in", i2c_data_in, 0);
        check("midrd_rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        mptr = 0;
        tick(3);
        rd_xfer(0, 1'b0, 1'b1);

        // Randomized mix of transactions.
        for (int t = 0; t < 24; t++) begin
            if ($urandom_range(0, 1) == 1)
                wr_xfer(8'($urandom), int'($urandom_range(0, 4)), $urandom_range(0, 3) != 0);
            else
                rd_xfer(int'($urandom_range(0, 3)), 1'b0, 1'b1);
        end
        do_stop();
        tick(10);

        check("pending_writes", exp_wr.size(), 0);
        check("pending_fetches", exp_ra.size(), 0);
        check("pending_bytes", exp_rd.size(), 0);
        for (int i = 0; i < DEPTH; i++) check("bank_final", pbank[i], mbank[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
